sram_responder: RTL and testbench

Target-side model of the core's SRAM-like buses: services the instruction-fetch port (read-only) and the data port (byte-enabled read/write) of the CPU core with fixed one-cycle read latency. Backs both ports with one shared word-addressed RAM and decodes a small configuration-register window on the data port (LED, number display, free-running timer with compare interrupt). Sits beside the core in the SoC top, wired directly to its inst_sram_* and data_sram_* pins.

---
 rtl/sram_resp_pkg.sv | 32 +++
 rtl/sram_responder_conf_regs.sv | 70 +++++++
 rtl/sram_responder.sv | 89 ++++++++
 tb/tb_sram_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_resp_pkg.sv
// Shared constants for the SRAM-bus responder: address mask, config-window
// selector, config register offsets, reset values and a byte-merge helper.
package sram_resp_pkg;

  localparam logic [31:0] PHYS_MASK   = 32'h1FFF_FFFF;
  localparam logic [12:0] CONF_HI_DEF = 13'h1FAF;

  // Byte offsets inside the config window.
  localparam logic [15:0] OFF_LED     = 16'h0000;
  localparam logic [15:0] OFF_NUM     = 16'h0004;
  localparam logic [15:0] OFF_TIMER   = 16'h0008;
  localparam logic [15:0] OFF_COMPARE = 16'h000C;

  localparam logic [31:0] RST_RDATA   = 32'h0000_0000;
  localparam logic [15:0] RST_LED     = 16'h0000;
  localparam logic [31:0] RST_NUM     = 32'h0000_0000;
  localparam logic [31:0] RST_TIMER   = 32'h0000_0000;
  localparam logic [31:0] RST_COMPARE = 32'hFFFF_FFFF;

  // Replace each byte lane of old_val whose enable bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  wen);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_responder_conf_regs.sv
// Config register window: LED, number display, free-running timer with
// compare interrupt, and the combinational read mux for the data port.
module conf_regs
  import sram_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [3:0]  wen,
  input  logic [13:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic [31:0] num,
  output logic        timer_int
);

  logic [31:0] timer;
  logic [31:0] compare;
  logic        hit_led, hit_num, hit_timer, hit_compare;
  logic [31:0] led_merged;
  logic [31:0] num_nxt, timer_nxt, compare_nxt;

  assign hit_led     = (word == OFF_LED[15:2]);
  assign hit_num     = (word == OFF_NUM[15:2]);
  assign hit_timer   = (word == OFF_TIMER[15:2]);
  assign hit_compare = (word == OFF_COMPARE[15:2]);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves a value unassigned (which would infer a latch).
  always_comb begin
    rdata = 32'h0;
    if (hit_led)     rdata = {16'h0, led};
    if (hit_num)     rdata = num;
    if (hit_timer)   rdata = timer;
    if (hit_compare) rdata = compare;
  end

  always_comb begin
    led_merged  = merge_bytes({16'h0, led}, wdata, wen);
    num_nxt     = (wr && hit_num)     ? merge_bytes(num, wdata, wen)     : num;
    compare_nxt = (wr && hit_compare) ? merge_bytes(compare, wdata, wen) : compare;
    // A write cycle suppresses the increment; unwritten bytes keep old value.
    timer_nxt   = (wr && hit_timer)   ? merge_bytes(timer, wdata, wen)   : timer + 32'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led       <= RST_LED;
      num       <= RST_NUM;
      timer     <= RST_TIMER;
      compare   <= RST_COMPARE;
      timer_int <= 1'b0;
    end else begin
      if (wr && hit_led) led <= led_merged[15:0];
      num     <= num_nxt;
      timer   <= timer_nxt;
      compare <= compare_nxt;
      // Clearing by a COMPARE write wins over a simultaneous match.
      if (wr && hit_compare)     timer_int <= 1'b0;
      else if (timer == compare) timer_int <= 1'b1;
    end
  end

  logic unused_led_hi;
  assign unused_led_hi = ^led_merged[31:16];

endmodule

// File: rtl/sram_responder.sv
// Target-side model of the core's instruction-fetch and data SRAM buses:
// shared word RAM with one-cycle read latency plus a config register window.
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int          MEM_AW  = 14,
  parameter logic [12:0] CONF_HI = CONF_HI_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] num,
  output logic        timer_int
);

  logic [31:0]       phys_i, phys_d;
  logic [MEM_AW-1:0] inst_idx, data_idx;
  logic              conf_sel;
  logic              data_rd, data_wr_ram, data_wr_conf;
  logic [31:0]       conf_rdata;

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  assign phys_i   = inst_sram_addr & PHYS_MASK;
  assign phys_d   = data_sram_addr & PHYS_MASK;
  assign inst_idx = phys_i[MEM_AW+1:2];
  assign data_idx = phys_d[MEM_AW+1:2];
  assign conf_sel = (phys_d[28:16] == CONF_HI);

  assign data_rd      = data_sram_en && (data_sram_wen == 4'h0);
  assign data_wr_ram  = data_sram_en && (data_sram_wen != 4'h0) && !conf_sel;
  assign data_wr_conf = data_sram_en && (data_sram_wen != 4'h0) && conf_sel;

  // NOTE: the RAM array has no reset; resetting it would prevent mapping onto
  // block RAM, and its contents are simply undefined after power-up.
  always_ff @(posedge clk) begin
    if (data_wr_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Both read ports sample the pre-edge array, so a same-word write in the
  // same cycle is seen only by the following read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_sram_rdata <= RST_RDATA;
    end else if (inst_sram_en) begin
      inst_sram_rdata <= mem[inst_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_sram_rdata <= RST_RDATA;
    end else if (data_rd) begin
      data_sram_rdata <= conf_sel ? conf_rdata : mem[data_idx];
    end
  end

  conf_regs u_conf_regs (
    .clk       (clk),
    .rst       (rst),
    .wr        (data_wr_conf),
    .wen       (data_sram_wen),
    .word      (phys_d[15:2]),
    .wdata     (data_sram_wdata),
    .rdata     (conf_rdata),
    .led       (led),
    .num       (num),
    .timer_int (timer_int)
  );

  // Fetch-port write inputs and unmapped address bits are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wen, inst_sram_wdata, phys_i, phys_d};

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: read expectations are queued when a
// request is driven and compared when the read data appears one cycle later.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_sram_en = 1'b0;
  logic [3:0]  inst_sram_wen = 4'h0;
  logic [31:0] inst_sram_addr = 32'h0;
  logic [31:0] inst_sram_wdata = 32'h0;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic [31:0] num;
  logic        timer_int;

  int total = 0;
  int bad = 0;

  logic [31:0] model [int];
  logic [31:0] exp_q [$];
  string       tag_q [$];
  bit          port_q [$];

  localparam logic [31:0] C_LED = 32'hBFAF_0000;
  localparam logic [31:0] C_NUM = 32'hBFAF_0004;
  localparam logic [31:0] C_TMR = 32'hBFAF_0008;
  localparam logic [31:0] C_CMP = 32'hBFAF_000C;
  localparam logic [31:0] C_BAD = 32'hBFAF_0010;

  sram_responder dut (
    .clk             (clk),
    .rst             (rst_n),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .num             (num),
    .timer_int       (timer_int)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    logic [31:0] p;
    p = a & 32'h1FFF_FFFF;
    return int'(p[15:2]);
  endfunction

  function automatic bit is_conf(input logic [31:0] a);
    logic [31:0] p;
    p = a & 32'h1FFF_FFFF;
    return p[28:16] == 13'h1FAF;
  endfunction

  // Advance one edge, retire every read issued for it, then go idle.
  task automatic cycle();
    logic [31:0] e;
    string t;
    bit p;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      p = port_q.pop_front();
      check(t, p ? data_sram_rdata : inst_sram_rdata, e);
    end
    inst_sram_en  = 1'b0;
    inst_sram_wen = 4'h0;
    data_sram_en  = 1'b0;
    data_sram_wen = 4'h0;
  endtask

  task automatic drv_ird(input logic [31:0] a, input string tag);
    inst_sram_en   = 1'b1;
    inst_sram_addr = a;
    exp_q.push_back(model[widx(a)]);
    tag_q.push_back(tag);
    port_q.push_back(1'b0);
  endtask

  task automatic drv_drd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'h0;
    data_sram_addr = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    port_q.push_back(1'b1);
  endtask

  task automatic drv_dwr(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] d);
    logic [31:0] old;
    data_sram_en    = 1'b1;
    data_sram_wen   = wen;
    data_sram_addr  = a;
    data_sram_wdata = d;
    if (!is_conf(a)) begin
      old = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
      for (int i = 0; i < 4; i++) if (wen[i]) old[8*i +: 8] = d[8*i +: 8];
      model[widx(a)] = old;
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_inst_rdata", inst_sram_rdata, 32'h0);
    check("rst_data_rdata", data_sram_rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_num", num, 32'h0);
    check("rst_irq", {31'h0, timer_int}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-word write, read back on both ports through different segments
    drv_dwr(32'h8000_0100, 4'hF, 32'hDEAD_BEEF);
    cycle();
    drv_drd(32'h8000_0100, 32'hDEAD_BEEF, "word_rd_data");
    drv_ird(32'hA000_0100, "word_rd_inst");
    cycle();
    cycle();
    check("rdata_hold_idle", data_sram_rdata, 32'hDEAD_BEEF);

    // Byte-lane write; write cycle leaves rdata untouched
    drv_dwr(32'h0000_0104, 4'hF, 32'h1122_3344);
    cycle();
    drv_dwr(32'h0000_0104, 4'b0010, 32'h0000_AB00);
    cycle();
    check("rdata_hold_write", data_sram_rdata, 32'hDEAD_BEEF);
    drv_drd(32'h0000_0104, 32'h1122_AB44, "byte_write");
    cycle();

    // Same-word fetch read and data write: read-before-write
    drv_dwr(32'h0000_0100, 4'hF, 32'h0000_0001);
    cycle();
    drv_ird(32'h0000_0100, "rbw_old");
    drv_dwr(32'h0000_0100, 4'hF, 32'h5555_5555);
    cycle();
    drv_ird(32'h0000_0100, "rbw_new");
    cycle();

    // Fetch-port writes are discarded; high index and aliasing above RAM size
    drv_ird(32'h0000_0102, "fetch_wen_ignored");
    inst_sram_wen = 4'hF;
    inst_sram_wdata = 32'h0BAD_0BAD;
    cycle();
    drv_ird(32'h0001_0100, "alias_hi_bits");
    cycle();
    drv_dwr(32'h0000_FFFC, 4'hF, 32'hCAFE_F00D);
    cycle();
    drv_ird(32'h0000_FFFC, "top_word_inst");
    drv_drd(32'h0000_FFFD, 32'hCAFE_F00D, "top_word_data_unaligned");
    cycle();

    // Config registers: LED, NUM, unmapped offset
    drv_dwr(C_LED, 4'hF, 32'h1234_5678);
    cycle();
    check("led_write", {16'h0, led}, 32'h0000_5678);
    drv_drd(C_LED, 32'h0000_5678, "led_read");
    cycle();
    drv_dwr(C_NUM, 4'b1100, 32'hCAFE_0000);
    cycle();
    check("num_upper", num, 32'hCAFE_0000);
    drv_dwr(C_NUM, 4'b0001, 32'hFFFF_FF42);
    cycle();
    drv_drd(C_NUM, 32'hCAFE_0042, "num_read");
    cycle();
    drv_dwr(C_BAD, 4'hF, 32'hFFFF_FFFF);
    cycle();
    drv_drd(C_BAD, 32'h0, "unmapped_read");
    cycle();

    // Timer wrap; reset COMPARE = FFFF_FFFF so the wrap also raises the irq
    drv_dwr(C_TMR, 4'hF, 32'hFFFF_FFFE);
    cycle();
    cycle();
    check("irq_before_match", {31'h0, timer_int}, 32'h0);
    drv_drd(C_TMR, 32'hFFFF_FFFF, "timer_ff");
    cycle();
    drv_drd(C_TMR, 32'h0000_0000, "timer_wrap");
    cycle();
    check("irq_after_wrap", {31'h0, timer_int}, 32'h1);

    // Compare interrupt 17 cycles after TIMER=0 with COMPARE=0x10
    drv_dwr(C_CMP, 4'hF, 32'h0000_0010);
    cycle();
    check("irq_clear_cmp", {31'h0, timer_int}, 32'h0);
    drv_dwr(C_TMR, 4'hF, 32'h0);
    cycle();
    for (int k = 1; k <= 20; k++) begin
      cycle();
      check($sformatf("irq_rise_k%0d", k), {31'h0, timer_int}, {31'h0, k >= 17});
    end
    drv_dwr(C_CMP, 4'hF, 32'h0000_0010);
    cycle();
    check("irq_clear_sticky", {31'h0, timer_int}, 32'h0);

    // Clear wins over a match in the same cycle
    drv_dwr(C_TMR, 4'hF, 32'h0);
    cycle();
    for (int k = 1; k <= 16; k++) cycle();
    check("irq_pre_collide", {31'h0, timer_int}, 32'h0);
    drv_dwr(C_CMP, 4'b0001, 32'h0000_0010);
    cycle();
    check("irq_clear_wins", {31'h0, timer_int}, 32'h0);
    cycle();
    check("irq_stays_clear", {31'h0, timer_int}, 32'h0);

    // Asynchronous reset in the middle of a read
    drv_ird(32'h0000_0104, "pre_rst_inst");
    drv_drd(32'h0000_0100, 32'h5555_5555, "pre_rst_data");
    cycle();
    inst_sram_en = 1'b1;
    inst_sram_addr = 32'h0000_0104;
    data_sram_en = 1'b1;
    data_sram_addr = 32'h0000_0104;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_led", {16'h0, led}, 32'h0);
    check("async_rst_num", num, 32'h0);
    check("async_rst_inst", inst_sram_rdata, 32'h0);
    check("async_rst_data", data_sram_rdata, 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_data", data_sram_rdata, 32'h0);
    inst_sram_en = 1'b0;
    data_sram_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drv_ird(32'h0000_0100, "post_rst_inst");
    drv_drd(32'h0000_0104, 32'h1122_AB44, "post_rst_data");
    cycle();
    drv_drd(C_CMP, 32'hFFFF_FFFF, "post_rst_compare");
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
